pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline latch that replaces the fixed per-boundary latches (fetch/decode, decode/execute, execute/memory, memory/writeback).
- Carries a WIDTH-bit packed payload with a valid/ready handshake and an optional 2-entry skid buffer.
- Obeys the hazard unit's 2-bit stage command: STALL / ENABLE / NOP / FLUSH.
- Adds per-stage stall, bubble and flush event counters for performance debug.

Parameters:
- WIDTH, 32: payload width in bits.
- NOP_VALUE, 0: payload value (WIDTH bits) loaded on NOP, FLUSH and reset.
- SKID, 1: 1 selects a 2-entry skid buffer with registered in_ready; 0 selects a single entry with combinational in_ready.
- CNT_W, 16: width of each event counter.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- state_i  in  2  stage command: 00 STALL, 01 ENABLE, 10 NOP, 11 FLUSH.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  payload valid to downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  payload to downstream; registered.
- clr_cnt  in  1  synchronous clear of all counters.
- stall_cnt  out  CNT_W  cycles spent in STALL.
- bubble_cnt  out  CNT_W  NOP cycles that inserted a bubble.
- flush_cnt  out  CNT_W  FLUSH cycles.

Behaviour:
- Storage:
  - Main entry: m_valid, m_data. Skid entry: s_valid, s_data (skid entry present only if SKID=1).
  - out_data = m_data.
  - out_valid = m_valid && (state_i != STALL).
- Reset (RST=1 at edge):
  - m_valid=0, s_valid=0, m_data=s_data=NOP_VALUE, all counters 0.
  - RST overrides state_i and clr_cnt; a reset mid-transfer drops both entries.
- in_ready:
  - STALL, NOP and FLUSH: 0.
  - ENABLE with SKID=1: !s_valid (depends only on registered state).
  - ENABLE with SKID=0: !m_valid || out_ready.
- Handshake events: acc = in_valid && in_ready; dq = out_valid && out_ready.
- ENABLE:
  - If dq or !m_valid: main loads the skid entry if s_valid (skid then empties, and acc writes the skid); otherwise main loads in_data when acc, or goes m_valid=0 when there is no acc.
  - If m_valid && !out_ready && acc (SKID=1 only): in_data goes to the skid; s_valid=1.
  - FIFO order is always preserved.
  - Latency from acceptance into an empty stage to out_valid: 1 cycle.
- STALL:
  - All entries frozen; no acceptance; no dequeue (out_valid gated low).
  - stall_cnt++.
- NOP:
  - No acceptance.
  - If dq or !m_valid: main gets m_valid=0, m_data=NOP_VALUE, and the skid entry is kept; bubble_cnt++.
  - Otherwise all entries hold and bubble_cnt does not change.
- FLUSH:
  - Main and skid both cleared (valid=0, data=NOP_VALUE).
  - A payload presented the same cycle is discarded.
  - flush_cnt++.
- Counters:
  - Saturate at 2^CNT_W-1; no wrap.
  - clr_cnt=1 zeroes all counters and wins over a simultaneous increment.
- Invariant: s_valid implies m_valid. Debug builds assert !(s_valid && !m_valid).
- state_i is sampled every cycle; no internal FSM latency. The command applies in the same cycle it is presented.

Test Plan:
- Reset, then ENABLE, in_valid=1, in_data=0x1234, out_ready=1 -> next cycle out_valid=1, out_data=0x1234; in_ready stays 1; streaming 0x1..0x8 back-to-back yields 0x1..0x8 in order, one per cycle.
- SKID=1, ENABLE, out_ready=0, send 0xA then 0xB -> out_data=0xA, s_valid=1, in_ready=0; set out_ready=1 -> 0xA then 0xB on consecutive cycles, in_ready returns to 1.
- Stage holding 0xC, STALL for 3 cycles with out_ready=1, in_valid=1 -> out_valid=0 and in_ready=0 throughout, data held; return to ENABLE -> 0xC delivered; stall_cnt=3.
- Full stage (0xD main, 0xE skid), FLUSH 1 cycle with in_valid=1, in_data=0xF -> next cycle out_valid=0, out_data=NOP_VALUE, 0xF never appears; flush_cnt=1.
- Empty stage, NOP 2 cycles -> out_valid=0, bubble_cnt=2; with main holding 0x5 and out_ready=0, NOP -> 0x5 held, bubble_cnt unchanged.
- CNT_W=4, STALL for 20 cycles -> stall_cnt saturates at 15; clr_cnt=1 during STALL -> stall_cnt=0 next cycle; RST=1 during a transfer -> all valids 0 and all counters 0 next cycle.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Generic pipeline boundary latch with a valid/ready handshake. It has an
//   optional 2-entry skid buffer and obeys the hazard unit's stage command
//   (STALL / ENABLE / NOP / FLUSH). It also keeps saturating stall, bubble and
//   flush event counters for performance debug.
//
// Parameters
//   WIDTH      payload width
//   NOP_VALUE  payload loaded on NOP, FLUSH and reset
//   SKID       1: 2-entry skid buffer, registered in_ready
//              0: single entry, combinational in_ready
//   CNT_W      width of each event counter
//
// Ports
//   CLK, RST               clock, synchronous active-high reset
//   state_i[1:0]           00 STALL, 01 ENABLE, 10 NOP, 11 FLUSH
//   in_valid/in_ready/in_data      upstream handshake and payload
//   out_valid/out_ready/out_data   downstream handshake and payload
//   clr_cnt                synchronous clear of all counters
//   stall_cnt, bubble_cnt, flush_cnt   event counters (saturating)
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0,
    parameter int               SKID      = 1,
    parameter int               CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [1:0]       state_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        CMD_STALL  = 2'b00,
        CMD_ENABLE = 2'b01,
        CMD_NOP    = 2'b10,
        CMD_FLUSH  = 2'b11
    } cmd_e;

    cmd_e cmd;
    assign cmd = cmd_e'(state_i);

    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_data_q,  m_data_d;
    logic             s_valid_q, s_valid_d;
    logic [WIDTH-1:0] s_data_q,  s_data_d;

    logic acc;
    logic dq;
    logic bubble_ev;

    // ---------------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------------
    assign out_data  = m_data_q;
    assign out_valid = m_valid_q && (cmd != CMD_STALL);

    always_comb begin
        in_ready = 1'b0;
        if (cmd == CMD_ENABLE) begin
            // With a skid buffer the ready depends only on flops, so it
            // never forms a combinational path from out_ready.
            if (SKID != 0) in_ready = !s_valid_q;
            else           in_ready = !m_valid_q || out_ready;
        end
    end

    assign acc = in_valid && in_ready;
    assign dq  = out_valid && out_ready;

    // ---------------------------------------------------------------------
    // Next-state of the main and skid entries
    // ---------------------------------------------------------------------
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        bubble_ev = 1'b0;
        case (cmd)
            CMD_ENABLE: begin
                if (dq || !m_valid_q) begin
                    if (s_valid_q) begin
                        // Skid is older than anything arriving now: it moves
                        // up first, so FIFO order is kept.
                        m_valid_d = 1'b1;
                        m_data_d  = s_data_q;
                        s_valid_d = acc;
                        if (acc) s_data_d = in_data;
                    end else begin
                        m_valid_d = acc;
                        if (acc) m_data_d = in_data;
                    end
                end else if (acc) begin
                    // Main is blocked downstream; only reachable with SKID=1.
                    s_valid_d = 1'b1;
                    s_data_d  = in_data;
                end
            end
            CMD_NOP: begin
                if (dq || !m_valid_q) begin
                    m_valid_d = 1'b0;
                    m_data_d  = NOP_VALUE;
                    bubble_ev = 1'b1;
                end
            end
            CMD_FLUSH: begin
                m_valid_d = 1'b0;
                m_data_d  = NOP_VALUE;
                s_valid_d = 1'b0;
                s_data_d  = NOP_VALUE;
            end
            default: ; // STALL: everything frozen
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            m_valid_q <= 1'b0;
            m_data_q  <= NOP_VALUE;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            always_ff @(posedge CLK) begin
                if (RST) begin
                    s_valid_q <= 1'b0;
                    s_data_q  <= NOP_VALUE;
                end else begin
                    s_valid_q <= s_valid_d;
                    s_data_q  <= s_data_d;
                end
            end
        end else begin : g_no_skid
            assign s_valid_q = 1'b0;
            assign s_data_q  = NOP_VALUE;
        end
    endgenerate

    // ---------------------------------------------------------------------
    // Event counters: index 0 stall, 1 bubble, 2 flush
    // ---------------------------------------------------------------------
    logic [2:0] cnt_inc;
    assign cnt_inc = {cmd == CMD_FLUSH, bubble_ev, cmd == CMD_STALL};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clr_cnt)                          cnt_d = '0;
                else if (cnt_inc[gi] && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
            end

            always_ff @(posedge CLK) begin
                if (RST) cnt_q <= '0;
                else     cnt_q <= cnt_d;
            end
        end
    endgenerate

    assign stall_cnt  = g_cnt[0].cnt_q;
    assign bubble_cnt = g_cnt[1].cnt_q;
    assign flush_cnt  = g_cnt[2].cnt_q;

`ifdef PIPE_STAGE_DEBUG
    // A NOP that dequeues while the skid is occupied leaves the skid ahead
    // of an empty main (the next ENABLE drains it first). The hazard unit is
    // expected not to issue that sequence, so it is flagged here.
    always_ff @(posedge CLK) begin
        if (!RST) assert (!(s_valid_q && !m_valid_q));
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Directed bench for pipe_stage_reg. dut: WIDTH=16, SKID=1, CNT_W=16.
//   dut_c: SKID=0, CNT_W=4, sharing the same stimulus (used for combinational
//   ready and counter saturation). A queue scoreboard tracks every payload
//   accepted by dut and checks it at the output in order.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam logic [15:0] NOPV   = 16'hBEEF;
    localparam logic [1:0]  STALL  = 2'b00;
    localparam logic [1:0]  ENABLE = 2'b01;
    localparam logic [1:0]  NOP    = 2'b10;
    localparam logic [1:0]  FLUSH  = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  state_i;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;
    logic        clr_cnt;

    logic        in_ready,  out_valid;
    logic [15:0] out_data;
    logic [15:0] stall_cnt, bubble_cnt, flush_cnt;

    logic        in_ready_c, out_valid_c;
    logic [15:0] out_data_c;
    logic [3:0]  stall_cnt_c, bubble_cnt_c, flush_cnt_c;

    logic [15:0] exp_q[$];
    logic [15:0] exp_v;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(16), .NOP_VALUE(NOPV), .SKID(1), .CNT_W(16)) dut (
        .CLK(clk), .RST(rst), .state_i(state_i),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .clr_cnt(clr_cnt), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
        .flush_cnt(flush_cnt)
    );

    pipe_stage_reg #(.WIDTH(16), .NOP_VALUE(NOPV), .SKID(0), .CNT_W(4)) dut_c (
        .CLK(clk), .RST(rst), .state_i(state_i),
        .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
        .clr_cnt(clr_cnt), .stall_cnt(stall_cnt_c), .bubble_cnt(bubble_cnt_c),
        .flush_cnt(flush_cnt_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle's inputs, let them settle, and run the scoreboard on
    // the handshakes that will complete at the next rising edge.
    task automatic drive(input logic [1:0] st, input logic iv, input logic [15:0] id,
                         input logic ordy);
        state_i   = st;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        if (in_valid && in_ready) exp_q.push_back(in_data);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_out", 32'(out_data), 32'(NOPV) ^ 32'hFFFF_FFFF);
            end else begin
                exp_v = exp_q.pop_front();
                chk("sb_data", 32'(out_data), 32'(exp_v));
                $display("xfer out %h", out_data);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clr_cnt = 1'b0;
        state_i = STALL; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // ---- reset state
        drive(ENABLE, 1'b0, 16'h0, 1'b1);
        chk("rst_out_valid",  32'(out_valid),  32'(0));
        chk("rst_out_data",   32'(out_data),   32'(NOPV));
        chk("rst_in_ready",   32'(in_ready),   32'(1));
        chk("rst_stall_cnt",  32'(stall_cnt),  32'(0));
        chk("rst_bubble_cnt", 32'(bubble_cnt), 32'(0));
        chk("rst_flush_cnt",  32'(flush_cnt),  32'(0));
        chk("rst_c_valid",    32'(out_valid_c), 32'(0));
        chk("rst_c_data",     32'(out_data_c),  32'(NOPV));
        chk("rst_c_bubble",   32'(bubble_cnt_c), 32'(0));
        chk("rst_c_flush",    32'(flush_cnt_c),  32'(0));
        tick();

        // ---- single transfer, 1-cycle latency
        drive(ENABLE, 1'b1, 16'h1234, 1'b1);
        chk("t1_in_ready", 32'(in_ready), 32'(1));
        tick();
        drive(ENABLE, 1'b0, 16'h0, 1'b1);
        chk("t1_out_valid", 32'(out_valid), 32'(1));
        chk("t1_out_data",  32'(out_data),  32'(16'h1234));
        tick();

        // ---- back-to-back stream 1..8
        for (int i = 1; i <= 8; i++) begin
            drive(ENABLE, 1'b1, 16'(i), 1'b1);
            chk("stream_in_ready", 32'(in_ready), 32'(1));
            if (i > 1) chk("stream_out_valid", 32'(out_valid), 32'(1));
            tick();
        end
        drive(ENABLE, 1'b0, 16'h0, 1'b1);
        chk("stream_last", 32'(out_data), 32'(8));
        tick();

        // ---- skid fill and drain
        drive(ENABLE, 1'b1, 16'hA, 1'b0);
        tick();
        drive(ENABLE, 1'b1, 16'hB, 1'b0);
        chk("skid_b_ready", 32'(in_ready),   32'(1));
        chk("noskid_ready", 32'(in_ready_c), 32'(0));
        tick();
        drive(ENABLE, 1'b0, 16'h0, 1'b0);
        chk("skid_full_ready", 32'(in_ready),  32'(0));
        chk("skid_main_data",  32'(out_data),  32'(16'hA));
        chk("skid_out_valid",  32'(out_valid), 32'(1));
        tick();
        drive(ENABLE, 1'b0, 16'h0, 1'b1);
        chk("drain_a", 32'(out_data), 32'(16'hA));
        tick();
        drive(ENABLE, 1'b0, 16'h0, 1'b1);
        chk("drain_b",       32'(out_data), 32'(16'hB));
        chk("drain_ready",   32'(in_ready), 32'(1));
        tick();

        // ---- stall for 3 cycles
        drive(ENABLE, 1'b1, 16'hC, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(STALL, 1'b1, 16'h99, 1'b1);
            chk("stall_out_valid", 32'(out_valid), 32'(0));
            chk("stall_in_ready",  32'(in_ready),  32'(0));
            chk("stall_data",      32'(out_data),  32'(16'hC));
            tick();
        end
        drive(ENABLE, 1'b0, 16'h0, 1'b1);
        chk("stall_release_valid", 32'(out_valid), 32'(1));
        chk("stall_cnt_3",         32'(stall_cnt), 32'(3));
        tick();

        // ---- flush a full stage
        drive(ENABLE, 1'b1, 16'hD, 1'b0);
        tick();
        drive(ENABLE, 1'b1, 16'hE, 1'b0);
        tick();
        drive(FLUSH, 1'b1, 16'hF, 1'b0);
        chk("flush_in_ready", 32'(in_ready), 32'(0));
        tick();
        exp_q.delete();
        drive(ENABLE, 1'b0, 16'h0, 1'b1);
        chk("flush_out_valid", 32'(out_valid), 32'(0));
        chk("flush_out_data",  32'(out_data),  32'(NOPV));
        chk("flush_cnt_1",     32'(flush_cnt), 32'(1));
        tick();
        drive(ENABLE, 1'b0, 16'h0, 1'b1);
        chk("flush_skid_gone", 32'(out_valid), 32'(0));
        tick();

        // ---- NOP on empty stage, then NOP while blocked
        for (int i = 0; i < 2; i++) begin
            drive(NOP, 1'b1, 16'h77, 1'b1);
            chk("nop_in_ready",  32'(in_ready),  32'(0));
            chk("nop_out_valid", 32'(out_valid), 32'(0));
            tick();
        end
        drive(ENABLE, 1'b1, 16'h5, 1'b0);
        chk("bubble_cnt_2", 32'(bubble_cnt), 32'(2));
        tick();
        drive(NOP, 1'b0, 16'h0, 1'b0);
        chk("nop_hold_valid", 32'(out_valid), 32'(1));
        tick();
        drive(ENABLE, 1'b0, 16'h0, 1'b0);
        chk("nop_hold_data",   32'(out_data),   32'(16'h5));
        chk("nop_hold_bubble", 32'(bubble_cnt), 32'(2));
        tick();
        drive(ENABLE, 1'b0, 16'h0, 1'b1);
        tick();

        // ---- reset during a transfer
        drive(ENABLE, 1'b1, 16'h42, 1'b0);
        tick();
        rst = 1'b1;
        drive(ENABLE, 1'b1, 16'h43, 1'b0);
        tick();
        rst = 1'b0;
        exp_q.delete();
        drive(ENABLE, 1'b0, 16'h0, 1'b1);
        chk("mrst_out_valid", 32'(out_valid),  32'(0));
        chk("mrst_out_data",  32'(out_data),   32'(NOPV));
        chk("mrst_stall",     32'(stall_cnt),  32'(0));
        chk("mrst_bubble",    32'(bubble_cnt), 32'(0));
        chk("mrst_flush",     32'(flush_cnt),  32'(0));
        tick();
        drive(ENABLE, 1'b0, 16'h0, 1'b1);
        chk("mrst_skid_gone", 32'(out_valid), 32'(0));
        tick();

        // ---- counter saturation and clear
        for (int i = 0; i < 20; i++) begin
            drive(STALL, 1'b0, 16'h0, 1'b0);
            tick();
        end
        chk("sat_stall_c", 32'(stall_cnt_c), 32'(15));
        chk("wide_stall",  32'(stall_cnt),   32'(20));
        clr_cnt = 1'b1;
        drive(STALL, 1'b0, 16'h0, 1'b0);
        tick();
        clr_cnt = 1'b0;
        chk("clr_stall_c", 32'(stall_cnt_c), 32'(0));
        chk("clr_stall",   32'(stall_cnt),   32'(0));
        drive(STALL, 1'b0, 16'h0, 1'b0);
        tick();
        chk("post_clr_stall_c", 32'(stall_cnt_c), 32'(1));
        chk("sb_empty", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
